// File: rtl/piano_pkg.sv
// Shared constants and state encoding for the piano record/playback sequencer.
package piano_pkg;

    localparam int DEPTH      = 8;
    localparam int ADDR_W     = 3;
    localparam int NUM_TRACKS = 4;
    localparam int NOTE_W     = 4;

    localparam logic [NOTE_W-1:0] REST_CODE = 4'hF;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t REC_WAIT = 3'd1;
    localparam state_t REC_WR   = 3'd2;
    localparam state_t REC_HOLD = 3'd3;
    localparam state_t REC_FULL = 3'd4;
    localparam state_t PLAY     = 3'd5;

endpackage

// File: rtl/step_timer.sv
// Playback step timer: counts 0..STEP_CYCLES-1 while enabled and pulses tc on the last count.
module step_timer #(
    parameter int STEP_CYCLES = 12500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piano_seq_ctrl.sv
// Record/playback control for the 4-track, 8-slot note memory: edge detect, FSM,
// write strobe decode and the shared playback read address.
module piano_seq_ctrl
    import piano_pkg::*;
#(
    parameter int STEP_CYCLES = 12500000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  mode,
    input  logic                  play,
    input  logic                  loop,
    input  logic [1:0]            track_sel,
    input  logic                  key_valid,
    input  logic [NOTE_W-1:0]     key_code,
    input  logic                  rest_req,
    output logic [NUM_TRACKS-1:0] wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [NOTE_W-1:0]     wr_data,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  play_gate,
    output logic                  busy,
    output logic                  rec_full,
    output logic                  step_pulse,
    output logic [2:0]            state_dbg
);

    state_t     state;
    logic       play_r, play_q;
    logic       key_r, key_q;
    logic [1:0] trk;
    logic       play_rise, key_rise;
    logic       tc;

    assign play_rise = play_r & ~play_q;
    assign key_rise  = key_r & ~key_q;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .CLK (CLK),
        .RST (RST),
        .clr (state != PLAY),
        .en  (state == PLAY),
        .tc  (tc)
    );

    // Memory write contract: wr_addr/wr_data are stable for the whole single
    // cycle in which exactly one wr_en bit is high; the memory captures on that edge.
    always_comb begin
        wr_en = '0;
        if (state == REC_WR) begin
            wr_en[trk] = 1'b1;
        end
    end

    assign play_gate = (state == PLAY);
    assign busy      = (state != IDLE);
    assign rec_full  = (state == REC_FULL);
    assign state_dbg = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            play_r     <= 1'b0;
            play_q     <= 1'b0;
            key_r      <= 1'b0;
            key_q      <= 1'b0;
            trk        <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_addr    <= '0;
            step_pulse <= 1'b0;
        end else begin
            play_r     <= play;
            play_q     <= play_r;
            key_r      <= key_valid;
            key_q      <= key_r;
            step_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (play_rise) begin
                        if (mode) begin
                            state   <= REC_WAIT;
                            wr_addr <= '0;
                            trk     <= track_sel;
                        end else begin
                            state      <= PLAY;
                            rd_addr    <= '0;
                            step_pulse <= 1'b1;
                        end
                    end
                end
                REC_WAIT: begin
                    if (!play) begin
                        state <= IDLE;
                    end else if (key_rise) begin
                        state   <= REC_WR;
                        wr_data <= key_code;
                    end else if (rest_req) begin
                        state   <= REC_WR;
                        wr_data <= REST_CODE;
                    end
                end
                // The strobe for this cycle is already out, so an abort here still lands the write.
                REC_WR: begin
                    if (!play) begin
                        state <= IDLE;
                    end else if (wr_addr == LAST_SLOT) begin
                        state <= REC_FULL;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                        state   <= REC_HOLD;
                    end
                end
                REC_HOLD: begin
                    if (!play) begin
                        state <= IDLE;
                    end else if (!key_r) begin
                        state <= REC_WAIT;
                    end
                end
                REC_FULL: begin
                    if (!play) begin
                        state <= IDLE;
                    end
                end
                PLAY: begin
                    if (!play) begin
                        state   <= IDLE;
                        rd_addr <= '0;
                    end else if (tc) begin
                        if (rd_addr != LAST_SLOT) begin
                            rd_addr    <= rd_addr + 1'b1;
                            step_pulse <= 1'b1;
                        end else if (loop) begin
                            rd_addr    <= '0;
                            step_pulse <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            rd_addr <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rd_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/piano_seq_ctrl.md
Name: piano_seq_ctrl

Overview:
- Record/playback sequencer for the 4-track, 8-slot note memory of the electronic piano.
- Record: captures one note per key press into the selected track, in order.
- Play: steps a shared read address through all 8 slots at a fixed tempo and gates the track tone generators.
- Replaces the ad-hoc control FSM, step counter and track write-clock decode with one synchronous block.

Parameters:
- STEP_CYCLES, 12500000, CLK cycles per playback step (note duration); legal range ≥2.
- DEPTH, 8, slots per track; fixed at 8, ADDR_W=3.
- NUM_TRACKS, 4, tracks; fixed at 4, track select is 2 bits.
- REST_CODE, 4'hF, code written for an explicit rest.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- mode  in  1  1 = record, 0 = play; sampled only in IDLE.
- play  in  1  level; rising edge starts the operation selected by mode; low aborts.
- loop  in  1  1 = playback wraps after slot 7.
- track_sel  in  2  record target track.
- key_valid  in  1  any piano key held (OR of p0..p9).
- key_code  in  4  binary key code 0..9, valid while key_valid=1.
- rest_req  in  1  single-cycle pulse; records REST_CODE in the current slot.
- wr_en  out  4  one-hot track write strobe, one CLK wide.
- wr_addr  out  3  record slot index.
- wr_data  out  4  note code to write.
- rd_addr  out  3  playback slot, shared by all tracks.
- play_gate  out  1  enables track tone generators.
- busy  out  1  state ≠ IDLE.
- rec_full  out  1  all 8 slots of the current record pass written.
- step_pulse  out  1  one-cycle pulse at each playback step start.

Behaviour:
- Async reset: state=IDLE; all outputs 0; step timer=0; edge registers=0.
- Edge detection: play and key_valid are registered internally; "rise" means current=1 and previous=0.

States and transitions:
- IDLE
  - On play rise with mode=1: go to REC_WAIT; wr_addr=0; latch track_sel.
  - On play rise with mode=0: go to PLAY; rd_addr=0; timer=0; step_pulse=1.
- REC_WAIT
  - On key_valid rise: go to REC_WR; wr_data=key_code.
  - Else on rest_req: go to REC_WR; wr_data=REST_CODE.
  - Same-cycle tie: key wins.
- REC_WR (1 cycle)
  - wr_en[latched track]=1.
  - If wr_addr==7: set rec_full=1, go to REC_FULL.
  - Else: wr_addr+1, go to REC_HOLD.
- REC_HOLD: wait for key_valid=0, then go to REC_WAIT. Prevents one held key filling several slots.
- REC_FULL: ignore all keys and rest_req; wr_en stays 0.
- PLAY
  - play_gate=1.
  - Timer counts 0..STEP_CYCLES-1.
  - At terminal count:
    - rd_addr≠7: rd_addr+1, step_pulse=1.
    - rd_addr==7 and loop=1: rd_addr=0, step_pulse=1.
    - rd_addr==7 and loop=0: go to IDLE.
  - loop is sampled only at the wrap point.

Abort and exit:
- play=0 in any non-IDLE state: go to IDLE next cycle.
- On exit to IDLE: play_gate=0, rd_addr=0, rec_full=0, no wr_en pulse.
- An abort and a REC_WR in the same cycle: the write completes, then the block goes to IDLE.

Other rules:
- mode and track_sel changes outside IDLE are ignored.
- Latency: key_valid rise → wr_en pulse = 2 CLK (edge register + REC_WR).
- Exactly one wr_en bit high, or none, in every cycle.
- Counter widths: the step timer is clog2(STEP_CYCLES) bits and never exceeds STEP_CYCLES-1. rd_addr and wr_addr wrap modulo 8 only as defined above.

Decomposition:
- Shared package piano_pkg holds:
  - state enum (IDLE, REC_WAIT, REC_WR, REC_HOLD, REC_FULL, PLAY);
  - REST_CODE, DEPTH, ADDR_W, NUM_TRACKS;
  - note code width constant (4).
- One sub-module: step_timer (parameter STEP_CYCLES; inputs CLK, RST, clr, en; output tc pulse).
- FSM, edge detect and address counters stay in piano_seq_ctrl.

Test Plan:
- Reset mid-PLAY (STEP_CYCLES=4, rd_addr=5): assert RST → all outputs 0 and state IDLE immediately, without waiting for a CLK edge.
- Record: mode=1, track_sel=2, play rise, then 8 presses with codes 3,1,4,1,5,9,2,6, each 3 cycles held → wr_en=4'b0100 with wr_addr 0..7 and matching wr_data. rec_full=1 after the 8th. A 9th press gives no wr_en.
- Held key plus rest: key code 7 held for 20 cycles → exactly one write (code 7, slot 0). Then rest_req pulse → write of 4'hF at slot 1.
- Playback (STEP_CYCLES=4, loop=0): play rise with mode=0 →
  - rd_addr steps 0..7, each held 4 cycles;
  - step_pulse ×8;
  - play_gate high for 32 cycles;
  - then IDLE with rd_addr=0.
- Loop and abort (STEP_CYCLES=4, loop=1): rd_addr goes 7→0 with step_pulse. Dropping play at rd_addr=3 gives play_gate=0 and rd_addr=0 on the next cycle.
- Ignored inputs: toggling mode/track_sel during PLAY has no effect. key_valid while in PLAY produces no wr_en.
